// File: rtl/sync_down_timer.sv
// Loadable, cascadable down-counter built from a per-bit toggle chain with borrow-out and done pulse.
// Define SYNC_DOWN_TIMER_AUTO_RELOAD_EN to reload and keep running at terminal count instead of stopping.
module sync_down_timer #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             stop,
   input  logic             cnt_en,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] T_in,
   output logic             borrow,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             done_q, done_d;
   logic             en;
   logic [WIDTH-1:0] tin;
   logic             borrow_w;

   assign en = cnt_en && (state_q == RUN);

   // Bit i toggles only when every lower bit is zero: a ripple borrow without an adder.
   always_comb begin
      tin    = '0;
      tin[0] = en;
      for (int unsigned i = 1; i < WIDTH; i++) begin
         tin[i] = tin[i-1] && !count_q[i-1];
      end
      borrow_w = tin[WIDTH-1] && !count_q[WIDTH-1];
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      done_d   = 1'b0;
      if (load) begin
         count_d  = load_val;
         reload_d = load_val;
         state_d  = IDLE;
      end else if (stop && (state_q == RUN)) begin
         state_d = IDLE;
      end else if (start && (state_q == IDLE)) begin
         state_d = RUN;
      end else if (start && (state_q == DONE)) begin
         count_d = reload_q;
         state_d = RUN;
      end else if (borrow_w) begin
         // Terminal count: the toggle update would wrap to all-ones, so it is never applied here.
         done_d = 1'b1;
`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
         count_d = reload_q;
`else
         state_d = DONE;
`endif
      end else begin
         count_d = count_q ^ tin;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         done_q   <= done_d;
      end
   end

   assign count  = count_q;
   assign T_in   = tin;
   assign borrow = borrow_w;
   assign busy   = (state_q == RUN);
   assign done   = done_q;

endmodule

// File: tb/tb_sync_down_timer.sv
// Self-checking bench for sync_down_timer: vector table, directed corner sequences,
// a two-stage cascade and randomized stimulus against a behavioural model.
module tb_sync_down_timer;

   localparam int W = 4;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;

   logic         clk = 1'b0;
   logic         rstn;
   logic         load, start, stop, cnt_en;
   logic [W-1:0] load_val;
   logic [W-1:0] count, T_in;
   logic         borrow, busy, done;

   // cascade pair
   logic         c_load, c_start, c_en;
   logic [3:0]   c_val;
   logic [3:0]   lo_count, lo_tin, hi_count, hi_tin;
   logic         lo_borrow, lo_busy, lo_done, hi_borrow, hi_busy, hi_done;

   int errors = 0;
   int checks = 0;

   // behavioural model state
   int m_cnt, m_rel, m_mode;
   bit m_done;

   // outputs sampled by the last drive() call
   int s_count, s_tin, s_borrow, s_busy, s_done;

   always #5 clk = ~clk;

   sync_down_timer #(.WIDTH(W)) dut (
      .clk(clk), .rstn(rstn), .load(load), .load_val(load_val), .start(start),
      .stop(stop), .cnt_en(cnt_en), .count(count), .T_in(T_in), .borrow(borrow),
      .busy(busy), .done(done)
   );

   sync_down_timer #(.WIDTH(4)) u_lo (
      .clk(clk), .rstn(rstn), .load(c_load), .load_val(c_val), .start(c_start),
      .stop(1'b0), .cnt_en(c_en), .count(lo_count), .T_in(lo_tin), .borrow(lo_borrow),
      .busy(lo_busy), .done(lo_done)
   );

   sync_down_timer #(.WIDTH(4)) u_hi (
      .clk(clk), .rstn(rstn), .load(c_load), .load_val(c_val), .start(c_start),
      .stop(1'b0), .cnt_en(lo_borrow), .count(hi_count), .T_in(hi_tin), .borrow(hi_borrow),
      .busy(hi_busy), .done(hi_done)
   );

   typedef struct {
      logic       l;
      logic [3:0] lv;
      logic       st, sp, ce;
      int         e_cnt, e_tin, e_borrow, e_busy, e_done;
   } vec_t;

   vec_t tbl[16];

   function automatic vec_t mk(input logic l, input int lv, input logic st, input logic sp,
                               input logic ce, input int ec, input int et, input int eb,
                               input int ebz, input int ed);
      vec_t v;
      v.l = l; v.lv = 4'(lv); v.st = st; v.sp = sp; v.ce = ce;
      v.e_cnt = ec; v.e_tin = et; v.e_borrow = eb; v.e_busy = ebz; v.e_done = ed;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_rel = 0; m_mode = M_IDLE; m_done = 0;
   endtask

   // Called just after a rising edge; returns just after the next rising edge.
   task automatic drive(input logic l, input int lv, input logic st, input logic sp, input logic ce);
      int m_en, m_borrow, m_tin;
      load = l; load_val = W'(lv); start = st; stop = sp; cnt_en = ce;
      @(negedge clk);
      m_en     = (ce && m_mode == M_RUN) ? 1 : 0;
      m_borrow = (m_en == 1 && m_cnt == 0) ? 1 : 0;
      m_tin    = 0;
      for (int i = 0; i < W; i++)
         if (m_en == 1 && (m_cnt % (1 << i)) == 0) m_tin |= (1 << i);
      s_count = int'(count); s_tin = int'(T_in); s_borrow = int'(borrow);
      s_busy = int'(busy); s_done = int'(done);
      chk("model_count",  s_count,  m_cnt);
      chk("model_T_in",   s_tin,    m_tin);
      chk("model_borrow", s_borrow, m_borrow);
      chk("model_busy",   s_busy,   (m_mode == M_RUN) ? 1 : 0);
      chk("model_done",   s_done,   int'(m_done));
      if (l) begin
         m_cnt = lv % (1 << W); m_rel = m_cnt; m_mode = M_IDLE; m_done = 0;
      end else begin
         m_done = 0;
         if (sp && m_mode == M_RUN) m_mode = M_IDLE;
         else if (st && m_mode == M_IDLE) m_mode = M_RUN;
         else if (st && m_mode == M_DONE) begin m_cnt = m_rel; m_mode = M_RUN; end
         else if (m_borrow == 1) begin
            m_done = 1;
`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
            m_cnt = m_rel;
`else
            m_mode = M_DONE;
`endif
         end else if (m_en == 1) m_cnt = m_cnt - 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      load = 0; load_val = '0; start = 0; stop = 0; cnt_en = 0;
      c_load = 0; c_val = '0; c_start = 0; c_en = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
   endtask

   initial begin
      int pulses, hit;

      // ---- reset state ----
      do_reset();
      cnt_en = 1'b1;
      #2;
      chk("reset_count",  int'(count),  0);
      chk("reset_T_in",   int'(T_in),   0);
      chk("reset_borrow", int'(borrow), 0);
      chk("reset_busy",   int'(busy),   0);
      chk("reset_done",   int'(done),   0);
      @(posedge clk); #1;

      // ---- vector table: priority, stop in IDLE, gating ----
      do_reset();
      tbl[0]  = mk(1, 5, 0, 0, 0,  0, 0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 1, 0, 0,  5, 0, 0, 0, 0);
      tbl[2]  = mk(0, 0, 0, 0, 1,  5, 1, 0, 1, 0);
      tbl[3]  = mk(1, 7, 1, 1, 1,  4, 7, 0, 1, 0);
      tbl[4]  = mk(0, 0, 0, 1, 0,  7, 0, 0, 0, 0);
      tbl[5]  = mk(0, 0, 1, 0, 0,  7, 0, 0, 0, 0);
      tbl[6]  = mk(0, 0, 0, 0, 1,  7, 1, 0, 1, 0);
      tbl[7]  = mk(0, 0, 0, 0, 1,  6, 3, 0, 1, 0);
      tbl[8]  = mk(0, 0, 0, 0, 1,  5, 1, 0, 1, 0);
      tbl[9]  = mk(0, 0, 0, 0, 1,  4, 7, 0, 1, 0);
      tbl[10] = mk(0, 0, 0, 0, 0,  3, 0, 0, 1, 0);
      tbl[11] = mk(0, 0, 0, 0, 0,  3, 0, 0, 1, 0);
      tbl[12] = mk(0, 0, 0, 0, 1,  3, 1, 0, 1, 0);
      tbl[13] = mk(0, 0, 0, 0, 0,  2, 0, 0, 1, 0);
      tbl[14] = mk(0, 0, 0, 1, 0,  2, 0, 0, 1, 0);
      tbl[15] = mk(0, 0, 0, 0, 0,  2, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].l, int'(tbl[i].lv), tbl[i].st, tbl[i].sp, tbl[i].ce);
         chk($sformatf("vec%0d_count", i),  s_count,  tbl[i].e_cnt);
         chk($sformatf("vec%0d_T_in", i),   s_tin,    tbl[i].e_tin);
         chk($sformatf("vec%0d_borrow", i), s_borrow, tbl[i].e_borrow);
         chk($sformatf("vec%0d_busy", i),   s_busy,   tbl[i].e_busy);
         chk($sformatf("vec%0d_done", i),   s_done,   tbl[i].e_done);
      end

      // ---- terminal-count behaviour ----
      do_reset();
      drive(1, 3, 0, 0, 0);
      drive(0, 0, 1, 0, 0);
`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         drive(0, 0, 0, 0, 1);
         chk("ar_count", s_count, 3 - (k % 4));
         chk("ar_borrow", s_borrow, (k % 4 == 3) ? 1 : 0);
         if (s_done == 1) pulses++;
      end
      drive(0, 0, 0, 0, 0);
      if (s_done == 1) pulses++;
      chk("ar_pulses", pulses, 3);
`else
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 0, 0, 1);
         chk("os_count", s_count, 3 - k);
         chk("os_borrow", s_borrow, (k == 3) ? 1 : 0);
      end
      drive(0, 0, 0, 0, 1);
      chk("os_done_pulse", s_done, 1);
      chk("os_busy_drop", s_busy, 0);
      chk("os_hold0", s_count, 0);
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 0, 1);
         chk("os_frozen", s_count, 0);
         chk("os_done_once", s_done, 0);
      end
      drive(0, 0, 1, 0, 1);
      drive(0, 0, 0, 0, 0);
      chk("os_restart_count", s_count, 3);
      chk("os_restart_busy", s_busy, 1);
`endif

      // ---- auto-reload period with N=2: four pulses in 12 enabled cycles ----
`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
      do_reset();
      drive(1, 2, 0, 0, 0);
      drive(0, 0, 1, 0, 0);
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         drive(0, 0, 0, 0, 1);
         chk("ar2_count", s_count, 2 - (k % 3));
         if (s_done == 1) pulses++;
      end
      drive(0, 0, 0, 0, 0);
      if (s_done == 1) pulses++;
      chk("ar2_pulses", pulses, 4);
`endif

      // ---- asynchronous reset mid-count ----
      do_reset();
      drive(1, 9, 0, 0, 0);
      drive(0, 0, 1, 0, 0);
      for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 1);
      chk("rst_pre_count", s_count, 7);
      #2;
      chk("rst_pre_edge_count", int'(count), 6);
      rstn = 1'b0;
      #1;
      chk("rst_async_count", int'(count), 0);
      chk("rst_async_busy",  int'(busy),  0);
      chk("rst_async_done",  int'(done),  0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;
      model_reset();
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 0, 0, 1);
         chk("rst_after_done", s_done, 0);
         chk("rst_after_busy", s_busy, 0);
      end

      // ---- cascade of two 4-bit stages ----
      do_reset();
      c_load = 1; c_val = 4'd15;
      @(posedge clk); #1;
      c_load = 0; c_start = 1;
      @(posedge clk); #1;
      c_start = 0; c_en = 1;
      hit = 0;
      for (int n = 1; n <= 400; n++) begin
         @(negedge clk);
         if (n == 16) begin
            chk("casc_lo_borrow16", int'(lo_borrow), 1);
            chk("casc_hi_count16", int'(hi_count), 15);
         end
         if (n == 17) chk("casc_hi_count17", int'(hi_count), 14);
`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
         if (n == 33) chk("casc_hi_count33", int'(hi_count), 13);
         if (hi_borrow && hit == 0) hit = n;
`else
         if (n == 17) chk("casc_lo_stopped", int'(lo_busy), 0);
         if (n == 40) chk("casc_hi_held", int'(hi_count), 14);
`endif
         @(posedge clk); #1;
         if (hit != 0 || n == 40 && hi_busy == 1'b1 && lo_busy == 1'b0) break;
      end
`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
      chk("casc_terminal_cycle", hit, 256);
`endif
      c_en = 0;

      // ---- randomized stimulus against the model ----
      do_reset();
      for (int k = 0; k < 800; k++) begin
         drive(($urandom_range(0, 15) == 0), int'($urandom_range(0, 6)),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0),
               ($urandom_range(0, 3) != 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
